systolic_feeder: RTL and testbench



---
 rtl/systolic_pkg.sv | 21 ++
 rtl/feeder_buf.sv | 72 +++++++
 rtl/systolic_feeder.sv | 189 ++++++++++++++++++
 tb/tb_systolic_feeder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array feeder: the fixed data word width,
// the word type and the feeder FSM state encoding.
// ----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/feeder_buf.sv
// ----------------------------------------------------------------------------
// feeder_buf
// Weight tile (DEPTH x PE_NUMBER words) and activation vector (DEPTH words)
// with one word-wide write port and one registered row-wide read port.
// Read latency is one cycle; when no read is requested the read register
// loads zero, so the outputs are quiet outside the streaming window.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset (read register only)
//   i_we         write strobe (already qualified by the caller)
//   i_sel        0 = weight memory, 1 = activation memory
//   i_row/i_col  write address (i_col ignored for activations)
//   i_data       write word
//   i_rd_en      load the read register from i_rd_addr, else load zero
//   i_rd_addr    row to read
//   o_row        registered weight row
//   o_act        registered activation word
// ----------------------------------------------------------------------------
module feeder_buf
    import systolic_pkg::*;
#(
    parameter int PE_NUMBER = 64,
    parameter int DEPTH     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_we,
    input  logic                         i_sel,
    input  logic [$clog2(DEPTH)-1:0]     i_row,
    input  logic [$clog2(PE_NUMBER)-1:0] i_col,
    input  logic [DATA_W-1:0]            i_data,
    input  logic                         i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]     i_rd_addr,
    output logic [DATA_W-1:0]            o_row [PE_NUMBER],
    output logic [DATA_W-1:0]            o_act
);

    word_t r_w_mem   [DEPTH][PE_NUMBER];
    word_t r_act_mem [DEPTH];
    word_t r_row     [PE_NUMBER];
    word_t r_act;

    // NOTE: the storage arrays are deliberately left out of reset; clearing
    // them would need a per-word reset path and the host reloads them anyway.
    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_sel) begin
                r_act_mem[i_row] <= i_data;
            end else begin
                r_w_mem[i_row][i_col] <= i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !i_rd_en) begin
            for (int c = 0; c < PE_NUMBER; c++) begin
                r_row[c] <= '0;
            end
            r_act <= '0;
        end else begin
            for (int c = 0; c < PE_NUMBER; c++) begin
                r_row[c] <= r_w_mem[i_rd_addr][c];
            end
            r_act <= r_act_mem[i_rd_addr];
        end
    end

    assign o_row = r_row;
    assign o_act = r_act;

endmodule

// File: rtl/systolic_feeder.sv
// ----------------------------------------------------------------------------
// systolic_feeder
// Upstream stage of the systolic array. The host loads a weight tile and an
// activation vector word by word while idle; a start command then clears the
// array, streams len rows (weights on top, activation on the left), flushes
// the array's column skew with zeros and finally drives the read phase.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   wr_en/wr_sel        host write strobe, 0 = weight, 1 = activation
//   wr_row/wr_col       host write address, wr_data word to store
//   start/len           begin a run of len rows (1..DEPTH), sampled in IDLE
//   busy                high in every state except IDLE
//   done                one-cycle pulse at end of run
//   err                 one-cycle pulse on a rejected write or start
//   arr_clear           array accumulator clear
//   arr_read            array read-phase enable
//   arr_l_d             activation into the array's left input
//   arr_t_w             weight row into the array's top inputs
// ----------------------------------------------------------------------------
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int PE_NUMBER = 64,
    parameter int DEPTH     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [$clog2(DEPTH)-1:0]     wr_row,
    input  logic [$clog2(PE_NUMBER)-1:0] wr_col,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   len,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         arr_clear,
    output logic                         arr_read,
    output logic [DATA_W-1:0]            arr_l_d,
    output logic [DATA_W-1:0]            arr_t_w [PE_NUMBER]
);

    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int LEN_W      = $clog2(DEPTH + 1);
    localparam int MAX_CNT    = (DEPTH > PE_NUMBER) ? DEPTH : PE_NUMBER;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);
    localparam int FLUSH_LAST = (PE_NUMBER > 1) ? PE_NUMBER - 2 : 0;
    localparam int DRAIN_LAST = PE_NUMBER - 1;

    feeder_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_clear;
    logic             r_read;

    logic             w_row_ok;
    logic             w_col_ok;
    logic             w_wr_reject;
    logic             w_wr_accept;
    logic             w_len_ok;
    logic [CNT_W-1:0] w_next_idx;
    logic             w_stream_last;
    logic             w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;

    // Index checks are done at 32 bits so they stay meaningful when DEPTH or
    // PE_NUMBER is not a power of two.
    assign w_row_ok    = 32'(wr_row) < DEPTH;
    assign w_col_ok    = wr_sel || (32'(wr_col) < PE_NUMBER);
    assign w_wr_reject = wr_en && ((r_state != IDLE) || !w_row_ok || !w_col_ok);
    assign w_wr_accept = wr_en && !w_wr_reject;
    assign w_len_ok    = (len != '0) && (32'(len) <= DEPTH);

    // The buffer has one cycle of read latency, so the address presented in
    // cycle k is the row that must appear on the outputs in cycle k+1.
    assign w_next_idx    = r_cnt + CNT_W'(1);
    assign w_stream_last = (w_next_idx == CNT_W'(r_len));
    assign w_rd_en       = (r_state == CLEAR) ||
                           ((r_state == STREAM) && !w_stream_last);
    assign w_rd_addr     = (r_state == CLEAR) ? '0 : w_next_idx[ADDR_W-1:0];

    feeder_buf #(
        .PE_NUMBER (PE_NUMBER),
        .DEPTH     (DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_wr_accept),
        .i_sel     (wr_sel),
        .i_row     (wr_row),
        .i_col     (wr_col),
        .i_data    (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_row     (arr_t_w),
        .o_act     (arr_l_d)
    );

    // NOTE: every state register and registered output uses <= so all of
    // them update together from the values seen before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_clear <= 1'b0;
            r_read  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_wr_reject;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_len   <= len;
                            r_state <= CLEAR;
                            r_busy  <= 1'b1;
                            r_clear <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    r_clear <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= STREAM;
                end
                STREAM: begin
                    if (w_stream_last) begin
                        r_cnt <= '0;
                        if (PE_NUMBER > 1) begin
                            r_state <= FLUSH;
                        end else begin
                            r_state <= DRAIN;
                            r_read  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_next_idx;
                    end
                end
                FLUSH: begin
                    if (r_cnt == CNT_W'(FLUSH_LAST)) begin
                        r_cnt   <= '0;
                        r_state <= DRAIN;
                        r_read  <= 1'b1;
                    end else begin
                        r_cnt <= w_next_idx;
                    end
                end
                DRAIN: begin
                    if (r_cnt == CNT_W'(DRAIN_LAST)) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                        r_read  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= w_next_idx;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_clear <= 1'b0;
                    r_read  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign arr_clear = r_clear;
    assign arr_read  = r_read;

endmodule

// File: tb/tb_systolic_feeder.sv
// ----------------------------------------------------------------------------
// tb_systolic_feeder
// Directed bench for systolic_feeder (PE_NUMBER=4, DEPTH=8). A second instance
// with PE_NUMBER=3, DEPTH=6 covers out-of-range write indices and lengths,
// since on the main instance the 2-bit column and 3-bit row ports cannot
// carry an out-of-range value.
// ----------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int PE     = 4;
    localparam int DEPTH  = 8;
    localparam int PE2    = 3;
    localparam int DEPTH2 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        reset;
    logic        wr_en, wr_sel;
    logic [2:0]  wr_row;
    logic [1:0]  wr_col;
    logic [15:0] wr_data;
    logic        start;
    logic [3:0]  len;
    logic        busy, done, err, arr_clear, arr_read;
    logic [15:0] arr_l_d;
    logic [15:0] arr_t_w [PE];

    // small instance
    logic        wr_en_b, wr_sel_b;
    logic [2:0]  wr_row_b;
    logic [1:0]  wr_col_b;
    logic [15:0] wr_data_b;
    logic        start_b;
    logic [2:0]  len_b;
    logic        busy_b, done_b, err_b, arr_clear_b, arr_read_b;
    logic [15:0] arr_l_d_b;
    logic [15:0] arr_t_w_b [PE2];

    int n_checks = 0;
    int n_fail   = 0;

    // reference copy of what the host has successfully written
    logic [15:0] m_w   [DEPTH][PE];
    logic [15:0] m_act [DEPTH];

    systolic_feeder #(.PE_NUMBER(PE), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .start(start), .len(len),
        .busy(busy), .done(done), .err(err),
        .arr_clear(arr_clear), .arr_read(arr_read),
        .arr_l_d(arr_l_d), .arr_t_w(arr_t_w)
    );

    systolic_feeder #(.PE_NUMBER(PE2), .DEPTH(DEPTH2)) u_dut_b (
        .clk(clk), .reset(reset),
        .wr_en(wr_en_b), .wr_sel(wr_sel_b), .wr_row(wr_row_b), .wr_col(wr_col_b), .wr_data(wr_data_b),
        .start(start_b), .len(len_b),
        .busy(busy_b), .done(done_b), .err(err_b),
        .arr_clear(arr_clear_b), .arr_read(arr_read_b),
        .arr_l_d(arr_l_d_b), .arr_t_w(arr_t_w_b)
    );

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic sel, input int row, input int col, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 3'(row);
        wr_col  = 2'(col);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic host_write_b(input logic sel, input int row, input int col, input logic [15:0] data);
        wr_en_b   = 1'b1;
        wr_sel_b  = sel;
        wr_row_b  = 3'(row);
        wr_col_b  = 2'(col);
        wr_data_b = data;
        tick();
        wr_en_b   = 1'b0;
    endtask

    function automatic logic [63:0] pack_tw();
        logic [63:0] v;
        for (int c = 0; c < PE; c++) v[16*c +: 16] = arr_t_w[c];
        return v;
    endfunction

    // Starts a run of n rows and compares every cycle until one cycle after
    // done against the expected schedule. With poke set, a weight write is
    // attempted in the first STREAM cycle and must be rejected.
    task automatic run_and_compare(input string tag, input int n, input bit poke);
        int          total;
        logic [4:0]  exp_ctrl, got_ctrl;
        logic [15:0] exp_ld;
        logic [63:0] exp_tw, got_tw;
        bit          in_stream;
        int          k;
        total = 1 + n + (PE - 1) + PE + 1;
        start = 1'b1;
        len   = 4'(n);
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= total + 1; cyc++) begin
            in_stream = (cyc >= 2) && (cyc < 2 + n);
            k         = cyc - 2;
            exp_ctrl  = {(cyc <= total),                                 // busy
                         (cyc == total),                                 // done
                         (poke && cyc == 3),                             // err
                         (cyc == 1),                                     // arr_clear
                         (cyc >= n + PE + 1) && (cyc < n + 2 * PE + 1)}; // arr_read
            exp_ld = 16'h0;
            exp_tw = 64'h0;
            if (in_stream) begin
                exp_ld = m_act[k];
                for (int c = 0; c < PE; c++) exp_tw[16*c +: 16] = m_w[k][c];
            end
            got_ctrl = {busy, done, err, arr_clear, arr_read};
            got_tw   = pack_tw();
            n_checks += 3;
            if (got_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL %s cycle %0d ctrl{busy,done,err,clear,read}: got %b expected %b",
                         tag, cyc, got_ctrl, exp_ctrl);
            end
            if (arr_l_d !== exp_ld) begin
                n_fail++;
                $display("FAIL %s cycle %0d arr_l_d: got %h expected %h", tag, cyc, arr_l_d, exp_ld);
            end
            if (got_tw !== exp_tw) begin
                n_fail++;
                $display("FAIL %s cycle %0d arr_t_w: got %h expected %h", tag, cyc, got_tw, exp_tw);
            end
            if (poke && cyc == 2) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd0; wr_col = 2'd0; wr_data = 16'hFFFF;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [4:0] got_ctrl;
        reset = 1'b1;
        tick();
        tick();
        got_ctrl = {busy, done, err, arr_clear, arr_read};
        n_checks += 3;
        if (got_ctrl !== 5'b0) begin
            n_fail++;
            $display("FAIL reset ctrl: got %b expected 00000", got_ctrl);
        end
        if (arr_l_d !== 16'h0) begin
            n_fail++;
            $display("FAIL reset arr_l_d: got %h expected 0000", arr_l_d);
        end
        if (pack_tw() !== 64'h0) begin
            n_fail++;
            $display("FAIL reset arr_t_w: got %h expected 0", pack_tw());
        end
        reset = 1'b0;
        tick();
        got_ctrl = {busy, done, err, arr_clear, arr_read};
        n_checks++;
        if (got_ctrl !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset ctrl: got %b expected 00000", got_ctrl);
        end
    endtask

    task automatic test_basic_run();
        int errs;
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < PE; c++) begin
                host_write(1'b0, k, c, 16'(16 * k + c));
                m_w[k][c] = 16'(16 * k + c);
                if (err !== 1'b0) errs++;
            end
            host_write(1'b1, k, 0, 16'(k + 1));
            m_act[k] = 16'(k + 1);
            if (err !== 1'b0) errs++;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL load_writes err pulses: got %0d expected 0", errs);
        end
        run_and_compare("basic_run", 3, 1'b0);
    endtask

    task automatic test_bad_len();
        logic [4:0] got_ctrl;
        logic [3:0] bad [2];
        bad[0] = 4'd0;
        bad[1] = 4'd9;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            len   = bad[i];
            tick();
            start = 1'b0;
            got_ctrl = {busy, done, err, arr_clear, arr_read};
            n_checks++;
            if (got_ctrl !== 5'b00100) begin
                n_fail++;
                $display("FAIL bad_len %0d pulse ctrl: got %b expected 00100", bad[i], got_ctrl);
            end
            tick();
            got_ctrl = {busy, done, err, arr_clear, arr_read};
            n_checks++;
            if (got_ctrl !== 5'b00000) begin
                n_fail++;
                $display("FAIL bad_len %0d after ctrl: got %b expected 00000", bad[i], got_ctrl);
            end
        end
    endtask

    task automatic test_write_while_busy();
        run_and_compare("busy_write", 3, 1'b1);
        run_and_compare("after_busy_write", 3, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        logic [4:0] got_ctrl;
        bit         seen;
        start = 1'b1;
        len   = 4'd3;
        tick();           // CLEAR
        start = 1'b0;
        tick();           // STREAM k=0
        tick();           // STREAM k=1
        n_checks++;
        if (arr_l_d !== m_act[1]) begin
            n_fail++;
            $display("FAIL mid_run arr_l_d before reset: got %h expected %h", arr_l_d, m_act[1]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got_ctrl = {busy, done, err, arr_clear, arr_read};
        n_checks += 2;
        if (got_ctrl !== 5'b0 || arr_l_d !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_run_reset ctrl/l_d: got %b/%h expected 00000/0000", got_ctrl, arr_l_d);
        end
        if (pack_tw() !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_run_reset arr_t_w: got %h expected 0", pack_tw());
        end
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_run_reset busy/done seen after abort: got 1 expected 0");
        end
        run_and_compare("after_reset", 3, 1'b0);
    endtask

    task automatic test_write_with_start();
        wr_en   = 1'b1;
        wr_sel  = 1'b1;
        wr_row  = 3'd0;
        wr_col  = 2'd0;
        wr_data = 16'h1234;
        m_act[0] = 16'h1234;
        run_and_compare("write_with_start", 1, 1'b0);
    endtask

    task automatic test_bad_index();
        int          errs;
        logic [47:0] got_tw;
        bit          seen_done;
        errs = 0;
        host_write_b(1'b0, 0, 0, 16'h00A0); if (err_b !== 1'b0) errs++;
        host_write_b(1'b0, 0, 1, 16'h00A1); if (err_b !== 1'b0) errs++;
        host_write_b(1'b0, 0, 2, 16'h00A2); if (err_b !== 1'b0) errs++;
        host_write_b(1'b1, 0, 3, 16'h0077); if (err_b !== 1'b0) errs++;  // column ignored for activations
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL idx_valid_writes err pulses: got %0d expected 0", errs);
        end
        host_write_b(1'b0, 0, 3, 16'hFFFF);
        n_checks++;
        if (err_b !== 1'b1) begin
            n_fail++;
            $display("FAIL idx_col_out_of_range err: got %b expected 1", err_b);
        end
        host_write_b(1'b1, 6, 0, 16'hFFFF);
        n_checks++;
        if (err_b !== 1'b1) begin
            n_fail++;
            $display("FAIL idx_row_out_of_range err: got %b expected 1", err_b);
        end
        start_b = 1'b1;
        len_b   = 3'd7;
        tick();
        start_b = 1'b0;
        n_checks++;
        if ({busy_b, err_b, arr_clear_b} !== 3'b010) begin
            n_fail++;
            $display("FAIL idx_len_over_depth {busy,err,clear}: got %b expected 010",
                     {busy_b, err_b, arr_clear_b});
        end
        start_b = 1'b1;
        len_b   = 3'd1;
        tick();           // CLEAR
        start_b = 1'b0;
        tick();           // STREAM k=0
        for (int c = 0; c < PE2; c++) got_tw[16*c +: 16] = arr_t_w_b[c];
        n_checks += 2;
        if (got_tw !== 48'h00A2_00A1_00A0) begin
            n_fail++;
            $display("FAIL idx_row0_unchanged arr_t_w: got %h expected 00a200a100a0", got_tw);
        end
        if (arr_l_d_b !== 16'h0077) begin
            n_fail++;
            $display("FAIL idx_act0 arr_l_d: got %h expected 0077", arr_l_d_b);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            tick();
            if (done_b === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL idx_run_done timeout: got no done expected done within 20 cycles");
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0; wr_sel   = 1'b0; wr_row   = '0; wr_col   = '0; wr_data   = '0;
        start   = 1'b0; len      = '0;
        wr_en_b = 1'b0; wr_sel_b = 1'b0; wr_row_b = '0; wr_col_b = '0; wr_data_b = '0;
        start_b = 1'b0; len_b    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m_act[k] = '0;
            for (int c = 0; c < PE; c++) m_w[k][c] = '0;
        end

        test_reset();
        test_basic_run();
        test_bad_len();
        test_write_while_busy();
        test_reset_mid_run();
        test_write_with_start();
        test_bad_index();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
